led_ws2812_frame_store: RTL and testbench



---
 rtl/led_ws2812_frame_store.sv | 145 ++++++++++++++
 tb/tb_led_ws2812_frame_store.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ws2812_frame_store.sv
// ---------------------------------------------------------------------------
// led_ws2812_frame_store
//
// Double-buffered LED frame store that feeds a WS2812 chain driver.
// The host writes pixels into the back bank. The chain reads pixels from the
// front bank through a 2-stage pipeline that applies global brightness
// scaling. A requested swap is held pending and takes effect on the next
// accepted request that starts a frame. This way a frame is never torn
// while it is being shifted out.
//
// Ports
//   clk, reset                : single clock, synchronous active-high reset
//   led_request__ready/first/led_number : chain asks for one LED's data
//   led_data__valid/last/red/green/blue : response, two cycles after accept
//   wr_valid/wr_index/wr_rgb  : host pixel write into the back bank
//   swap_req                  : request a front/back exchange
//   num_leds                  : chain length 1..64 (0 behaves as 1)
//   brightness                : global scale, out = c*(brightness+1) >> 8
//   swap_done                 : pulses in the cycle the swap is taken
//   overrun                   : sticky, a request arrived while busy
// ---------------------------------------------------------------------------
module led_ws2812_frame_store (
  input  logic        clk,
  input  logic        reset,
  input  logic        led_request__ready,
  input  logic        led_request__first,
  input  logic [7:0]  led_request__led_number,
  output logic        led_data__valid,
  output logic        led_data__last,
  output logic [7:0]  led_data__red,
  output logic [7:0]  led_data__green,
  output logic [7:0]  led_data__blue,
  input  logic        wr_valid,
  input  logic [5:0]  wr_index,
  input  logic [23:0] wr_rgb,
  input  logic        swap_req,
  input  logic [6:0]  num_leds,
  input  logic [7:0]  brightness,
  output logic        swap_done,
  output logic        overrun
);

  // Both banks share one array. The top address bit selects the bank.
  logic [23:0] mem [0:127];

  logic        front_sel_reg;
  logic        swap_pending_reg;
  logic        overrun_reg;
  logic        s1_valid_reg;
  logic        s1_last_reg;
  logic        s1_oor_reg;
  logic [23:0] rd_data_reg;

  logic        busy;
  logic        accept;
  logic        drop;
  logic        swap_now;
  logic        front_sel_next;
  logic [7:0]  eff_num;
  logic        req_oor;
  logic        req_last;
  logic [6:0]  rd_addr;
  logic [6:0]  wr_addr;
  logic [7:0]  scaled [0:2];

  always_comb begin
    // The output register doubles as the stage-2 valid flag.
    busy           = s1_valid_reg | led_data__valid;
    accept         = led_request__ready & ~busy;
    drop           = led_request__ready & busy;
    // A swap_req in the same cycle counts as already pending.
    swap_now       = accept & led_request__first & (swap_pending_reg | swap_req);
    front_sel_next = front_sel_reg ^ swap_now;
    eff_num        = (num_leds == 7'd0) ? 8'd1 : {1'b0, num_leds};
    req_oor        = led_request__led_number >= eff_num;
    req_last       = req_oor | (led_request__led_number == eff_num - 8'd1);
    // The read uses the post-swap front. The write uses the pre-swap back.
    rd_addr        = {front_sel_next, led_request__led_number[5:0]};
    wr_addr        = {~front_sel_reg, wr_index};
    swap_done      = swap_now & ~reset;
    overrun        = overrun_reg;
  end

  // Per-component scaling: components 0,1,2 = red, green, blue.
  for (genvar gi = 0; gi < 3; gi++) begin : g_scale
    logic [16:0] prod;
    always_comb begin
      prod        = {9'd0, rd_data_reg[23 - 8*gi -: 8]} * ({9'd0, brightness} + 17'd1);
      scaled[gi]  = 8'(prod >> 8);
    end
  end

  // Block RAM: write port for the host, registered read port for stage 1.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem[wr_addr] <= wr_rgb;
    end
    if (accept) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
      overrun_reg      <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s1_last_reg      <= 1'b0;
      s1_oor_reg       <= 1'b0;
      led_data__valid  <= 1'b0;
      led_data__last   <= 1'b0;
      led_data__red    <= 8'd0;
      led_data__green  <= 8'd0;
      led_data__blue   <= 8'd0;
    end else begin
      front_sel_reg <= front_sel_next;
      if (swap_now) begin
        swap_pending_reg <= 1'b0;
      end else if (swap_req) begin
        swap_pending_reg <= 1'b1;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end

      // Stage 1: fetch and classify.
      s1_valid_reg <= accept;
      if (accept) begin
        s1_last_reg <= req_last;
        s1_oor_reg  <= req_oor;
      end

      // Stage 2: scale. The data outputs hold their values between pulses.
      led_data__valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        led_data__last  <= s1_last_reg;
        led_data__red   <= s1_oor_reg ? 8'd0 : scaled[0];
        led_data__green <= s1_oor_reg ? 8'd0 : scaled[1];
        led_data__blue  <= s1_oor_reg ? 8'd0 : scaled[2];
      end
    end
  end

endmodule

// File: tb/tb_led_ws2812_frame_store.sv
// ---------------------------------------------------------------------------
// tb_led_ws2812_frame_store
//
// Randomised bench with a scoreboard. The driver keeps a behavioural model
// of the frame store: two pixel arrays, a front index and a pending flag.
// For each request it pushes the expected response, tagged with the cycle
// in which the response must appear. The monitor compares every cycle.
// ---------------------------------------------------------------------------
module tb_led_ws2812_frame_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        led_request__ready = 1'b0;
  logic        led_request__first = 1'b0;
  logic [7:0]  led_request__led_number = 8'd0;
  logic        led_data__valid;
  logic        led_data__last;
  logic [7:0]  led_data__red;
  logic [7:0]  led_data__green;
  logic [7:0]  led_data__blue;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_index = 6'd0;
  logic [23:0] wr_rgb = 24'd0;
  logic        swap_req = 1'b0;
  logic [6:0]  num_leds = 7'd8;
  logic [7:0]  brightness = 8'd255;
  logic        swap_done;
  logic        overrun;

  led_ws2812_frame_store dut (
    .clk                     (clk),
    .reset                   (reset),
    .led_request__ready      (led_request__ready),
    .led_request__first      (led_request__first),
    .led_request__led_number (led_request__led_number),
    .led_data__valid         (led_data__valid),
    .led_data__last          (led_data__last),
    .led_data__red           (led_data__red),
    .led_data__green         (led_data__green),
    .led_data__blue          (led_data__blue),
    .wr_valid                (wr_valid),
    .wr_index                (wr_index),
    .wr_rgb                  (wr_rgb),
    .swap_req                (swap_req),
    .num_leds                (num_leds),
    .brightness              (brightness),
    .swap_done               (swap_done),
    .overrun                 (overrun)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int         cyc;
    logic       last;
    logic [7:0] r, g, b;
  } exp_t;
  exp_t sb[$];

  logic exp_swap_done = 1'b0;
  logic exp_overrun   = 1'b0;
  bit   done          = 1'b0;

  // Behavioural model state, driver-owned.
  logic [23:0] bank [0:1][0:63];
  int          m_sel = 0;
  bit          m_pend = 0;
  bit          m_ovr = 0;
  int          last_acc = -100;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    int v;
    v = (int'(c) * (int'(b) + 1)) / 256;
    return v[7:0];
  endfunction

  // One clock cycle of stimulus. Inputs change 2 time units after the rising edge.
  task automatic step(input bit rq, input bit first, input logic [7:0] num,
                      input bit wv, input logic [5:0] wi, input logic [23:0] wd,
                      input bit sw, input bit rst,
                      input bit chg, input logic [7:0] nb, input logic [6:0] nn);
    int   old_sel, eff, n;
    bit   acc;
    exp_t e;
    logic [23:0] px;
    @(posedge clk);
    #2;
    // Brightness may change only after the last response has been scaled.
    if (chg && (cyc - last_acc >= 1)) begin
      brightness = nb;
      num_leds   = nn;
    end
    reset                   = rst;
    led_request__ready      = rq;
    led_request__first      = first;
    led_request__led_number = num;
    wr_valid                = wv;
    wr_index                = wi;
    wr_rgb                  = wd;
    swap_req                = sw;
    exp_overrun             = m_ovr;
    exp_swap_done           = 1'b0;
    if (rst) begin
      m_sel    = 0;
      m_pend   = 0;
      m_ovr    = 0;
      last_acc = -100;
    end else begin
      old_sel = m_sel;
      // The pipeline is busy for two edges after each accepted request.
      acc = rq && ((cyc + 1) - last_acc >= 3);
      if (rq && !acc) m_ovr = 1;
      if (acc && first && (m_pend || sw)) begin
        m_sel  = 1 - m_sel;
        m_pend = 0;
        exp_swap_done = 1'b1;
      end else if (sw) begin
        m_pend = 1;
      end
      if (acc) begin
        last_acc = cyc + 1;
        eff = (num_leds == 0) ? 1 : int'(num_leds);
        n   = int'(num);
        px  = bank[m_sel][num[5:0]];
        e.cyc  = cyc + 2;
        e.last = (n >= eff) || (n == eff - 1);
        if (n >= eff) begin
          e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
        end else begin
          e.r = scale(px[23:16], brightness);
          e.g = scale(px[15:8],  brightness);
          e.b = scale(px[7:0],   brightness);
        end
        sb.push_back(e);
      end
      // The write lands after the read, in the back bank that was current before the swap.
      if (wv) bank[1 - old_sel][wi] = wd;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / checker ----------------
  int   n_chk = 0;
  int   n_pass = 0;
  bit   armed = 0;
  logic       h_last;
  logic [7:0] h_r, h_g, h_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      armed = 1;
      sb.delete();
      h_last = 1'b0; h_r = 8'd0; h_g = 8'd0; h_b = 8'd0;
    end
    if (done) begin
      chk("drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end else if (armed) begin
      chk("swap_done", swap_done, exp_swap_done);
      chk("overrun", overrun, exp_overrun);
      if (led_data__valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", led_data__valid, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("last", led_data__last, e.last);
          chk("red", led_data__red, e.r);
          chk("green", led_data__green, e.g);
          chk("blue", led_data__blue, e.b);
          h_last = e.last; h_r = e.r; h_g = e.g; h_b = e.b;
        end
      end else begin
        chk("valid", led_data__valid, 0);
        chk("hold", {led_data__last, led_data__red, led_data__green, led_data__blue},
            {h_last, h_r, h_g, h_b});
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("missing_valid", 0, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit rq, fi, wv, sw, chg;
    // Reset, then fill bank 1 (back after reset).
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 6'(i), 24'($urandom), 0, 0, 0, 0, 0);
    // Swap so that bank 1 is front, then fill bank 0.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 6'(i), 24'($urandom), 0, 0, 0, 0, 0);
    idle(3);
    // Directed checks: basic read, scaling and last, out of range, num_leds=0.
    step(0, 0, 0, 1, 6'd3, 24'h102030, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6'd7, 24'hFF8001, 1, 0, 1, 8'd255, 7'd8);
    step(1, 1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 8'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 8'd7, 0, 0, 0, 0, 0, 1, 8'd127, 7'd8);
    idle(2);
    step(1, 0, 8'd10, 0, 0, 0, 0, 0, 1, 8'd200, 7'd4);
    idle(2);
    step(1, 0, 8'd0, 0, 0, 0, 0, 0, 1, 8'd200, 7'd0);
    idle(3);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rq  = ($urandom % 100) < 40;
      fi  = ($urandom % 4) == 0;
      wv  = ($urandom % 2) == 1;
      sw  = ($urandom % 100) < 8;
      chg = ($urandom % 20) == 0;
      step(rq, fi, 8'($urandom_range(0, 80)), wv, 6'($urandom), 24'($urandom), sw, 0,
           chg, 8'($urandom), 7'($urandom_range(0, 64)));
    end
    idle(3);
    // Overrun: back-to-back requests after a clean reset.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 8'd2, 0, 0, 0, 0, 0, 1, 8'd255, 7'd8);
    step(1, 0, 8'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // Reset in the cycle after acceptance, with a swap pending.
    step(1, 0, 8'd5, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(4);
    step(1, 1, 8'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 8'd6, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    done = 1;
  end

endmodule
